// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: serialises one 48-bit SD command frame onto the CMD line.
// Frame layout: start(0), tx(1), index[5:0], arg[31:0], CRC7[6:0], end(1).
// CRC7 (x^7+x^3+1) is accumulated MSB first over the first 40 frame bits.
// Optional feature macro: SD_CMD_PAD_EN adds PAD_BITS idle-high bit periods
// (pad released, strobes still running) after the end bit.
// CLK_DIV must be >= 2; PAD_BITS must be >= 1 when the pad feature is built.
module sd_cmd_tx #(
    parameter int CLK_DIV  = 4,
    parameter int PAD_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        bit_strobe,
    output logic [6:0]  crc_out
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BIT_MAX = (PAD_BITS > 40) ? PAD_BITS : 40;
    localparam int BIT_W   = $clog2(BIT_MAX);

    // Divider value one cycle before the last cycle of a bit period; the
    // strobe is registered so it is high exactly while divider == CLK_DIV-1.
    localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(CLK_DIV - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(39);
    localparam logic [BIT_W-1:0] CRC_LAST  = BIT_W'(6);
`ifdef SD_CMD_PAD_EN
    localparam logic [BIT_W-1:0] PAD_LAST  = BIT_W'(PAD_BITS - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_CRC  = 3'd2,
        ST_STOP = 3'd3,
        ST_PAD  = 3'd4
    } state_t;

    // One CRC7 step: feedback is the incoming bit xor the CRC MSB.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic inv;
        inv = bit_in ^ crc[6];
        return {crc[5:3], crc[2] ^ inv, crc[1:0], inv};
    endfunction

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic [39:0]       r_shift;
    logic [6:0]        r_crc;
    logic              r_busy;
    logic              r_done;
    logic              r_cmd_out;
    logic              r_cmd_oe;
    logic              r_bit_strobe;

    logic [39:0]       w_frame_init;
    logic [6:0]        w_crc_next;

    assign w_frame_init = {1'b0, 1'b1, cmd_index, cmd_arg};
    // CRC advances with the bit currently on the line.
    assign w_crc_next   = crc7_next(r_crc, r_cmd_out);

    // Frame sequencer: bit timing, shifting, CRC and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= 40'd0;
            r_crc        <= 7'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cmd_out    <= 1'b1;
            r_cmd_oe     <= 1'b0;
            r_bit_strobe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_div        <= '0;
                r_bit_strobe <= 1'b0;
            end else begin
                r_div        <= r_bit_strobe ? '0 : (r_div + DIV_W'(1));
                r_bit_strobe <= (!r_bit_strobe) && (r_div == DIV_PRE);
            end
            case (r_state)
                ST_IDLE: begin
                    // A start on the done cycle is dropped: r_done still high.
                    if (start && !r_done) begin
                        r_state   <= ST_DATA;
                        r_shift   <= w_frame_init;
                        r_crc     <= 7'd0;
                        r_bit     <= '0;
                        r_busy    <= 1'b1;
                        r_cmd_oe  <= 1'b1;
                        r_cmd_out <= w_frame_init[39];
                    end else begin
                        r_busy    <= 1'b0;
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_bit_strobe) begin
                        r_crc <= w_crc_next;
                        if (r_bit == DATA_LAST) begin
                            // Shift out a copy of the final CRC; crc_out stays frozen.
                            r_state   <= ST_CRC;
                            r_bit     <= '0;
                            r_shift   <= {w_crc_next, 33'd0};
                            r_cmd_out <= w_crc_next[6];
                        end else begin
                            r_bit     <= r_bit + BIT_W'(1);
                            r_shift   <= {r_shift[38:0], 1'b0};
                            r_cmd_out <= r_shift[38];
                        end
                    end
                end
                ST_CRC: begin
                    if (r_bit_strobe) begin
                        if (r_bit == CRC_LAST) begin
                            r_state   <= ST_STOP;
                            r_bit     <= '0;
                            r_cmd_out <= 1'b1;
                        end else begin
                            r_bit     <= r_bit + BIT_W'(1);
                            r_shift   <= {r_shift[38:0], 1'b0};
                            r_cmd_out <= r_shift[38];
                        end
                    end
                end
                ST_STOP: begin
                    if (r_bit_strobe) begin
`ifdef SD_CMD_PAD_EN
                        // Release the pad but keep clocking for the card.
                        r_state   <= ST_PAD;
                        r_bit     <= '0;
                        r_cmd_out <= 1'b1;
                        r_cmd_oe  <= 1'b0;
`else
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_cmd_oe  <= 1'b0;
                        r_cmd_out <= 1'b1;
`endif
                    end
                end
`ifdef SD_CMD_PAD_EN
                ST_PAD: begin
                    if (r_bit_strobe) begin
                        if (r_bit == PAD_LAST) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_cmd_oe     <= 1'b0;
                    r_cmd_out    <= 1'b1;
                    r_bit_strobe <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign cmd_out    = r_cmd_out;
    assign cmd_oe     = r_cmd_oe;
    assign bit_strobe = r_bit_strobe;
    assign crc_out    = r_crc;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Testbench for sd_cmd_tx (CLK_DIV=4, PAD_BITS=8). Table of command vectors
// with hand-computed frames/CRCs, plus hand-written reset-abort sequence.
module tb_sd_cmd_tx;

`ifdef SD_CMD_PAD_EN
    localparam int EXP_DONE   = 225;
    localparam int EXP_STROBE = 56;
`else
    localparam int EXP_DONE   = 193;
    localparam int EXP_STROBE = 48;
`endif
    localparam int WINDOW = EXP_DONE + 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy, done, cmd_out, cmd_oe, bit_strobe;
    logic [6:0]  crc_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [47:0] frame;
        logic [6:0]  crc;
        bit          poke;
    } vec_t;

    vec_t vecs [5];

    // Results of the last run_frame call.
    logic [47:0] got_frame;
    int          got_done_cyc, got_strobes, got_dones;
    bit          oe_bad, stab_bad, idle_bad, start_bad, done_bad;
    logic [6:0]  crc_at1;

    sd_cmd_tx #(.CLK_DIV(4), .PAD_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .busy(busy), .done(done), .cmd_out(cmd_out),
        .cmd_oe(cmd_oe), .bit_strobe(bit_strobe), .crc_out(crc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one command and observe a fixed window; optionally pulse start
    // mid-frame (cycle 80) and again on the done cycle.
    task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg, input bit poke);
        int  cyc;
        bit  prev_strobe;
        logic prev_out;
        @(negedge clk);
        cmd_index = idx;
        cmd_arg   = arg;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got_frame = 48'd0; got_done_cyc = -1; got_strobes = 0; got_dones = 0;
        oe_bad = 1'b0; stab_bad = 1'b0; idle_bad = 1'b0; start_bad = 1'b0; done_bad = 1'b0;
        crc_at1 = 7'h7F; prev_strobe = 1'b0; prev_out = 1'b1;
        cyc = 0;
        while (cyc < WINDOW) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                crc_at1 = crc_out;
                if (busy !== 1'b1 || cmd_oe !== 1'b1 || cmd_out !== 1'b0) start_bad = 1'b1;
            end else if (cmd_out !== prev_out && !prev_strobe) begin
                stab_bad = 1'b1;
            end
            if (bit_strobe) begin
                got_strobes++;
                if (got_strobes <= 48) begin
                    got_frame = {got_frame[46:0], cmd_out};
                    if (cmd_oe !== 1'b1) oe_bad = 1'b1;
                end else if (cmd_oe !== 1'b0 || cmd_out !== 1'b1) begin
                    oe_bad = 1'b1;
                end
            end
            if (done) begin
                got_dones++;
                if (got_done_cyc < 0) got_done_cyc = cyc;
                if (busy !== 1'b0 || cmd_oe !== 1'b0) done_bad = 1'b1;
            end
            if (got_done_cyc > 0 && cyc > got_done_cyc && (busy !== 1'b0 || cmd_oe !== 1'b0))
                idle_bad = 1'b1;
            if (poke && cyc == 80) begin
                cmd_index = 6'd63;
                cmd_arg   = 32'hFFFF_FFFF;
                start     = 1'b1;
            end
            if (poke && done && got_dones == 1) start = 1'b1;
            prev_strobe = bit_strobe;
            prev_out    = cmd_out;
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input vec_t v, input string tag);
        chk({tag, "_frame"},     64'(got_frame), 64'(v.frame));
        chk({tag, "_crc"},       64'(crc_out), 64'(v.crc));
        chk({tag, "_crc_clr"},   64'(crc_at1), 64'd0);
        chk({tag, "_done_cyc"},  64'(got_done_cyc), 64'(EXP_DONE));
        chk({tag, "_strobes"},   64'(got_strobes), 64'(EXP_STROBE));
        chk({tag, "_dones"},     64'(got_dones), 64'd1);
        chk({tag, "_start_st"},  64'(start_bad), 64'd0);
        chk({tag, "_oe"},        64'(oe_bad), 64'd0);
        chk({tag, "_stable"},    64'(stab_bad), 64'd0);
        chk({tag, "_done_st"},   64'(done_bad), 64'd0);
        chk({tag, "_idle_after"},64'(idle_bad), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_0000_0000_95, crc: 7'h4A, poke: 1'b0};
        vecs[1] = '{idx: 6'd8,  arg: 32'h0000_01AA, frame: 48'h48_0000_01AA_87, crc: 7'h43, poke: 1'b0};
        vecs[2] = '{idx: 6'd17, arg: 32'h0000_0000, frame: 48'h51_0000_0000_55, crc: 7'h2A, poke: 1'b0};
        vecs[3] = '{idx: 6'd55, arg: 32'h0000_0000, frame: 48'h77_0000_0000_65, crc: 7'h32, poke: 1'b0};
        vecs[4] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_0000_0000_95, crc: 7'h4A, poke: 1'b1};

        reset = 1'b1; start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_cmd",    64'(cmd_out), 64'd1);
        chk("rst_oe",     64'(cmd_oe), 64'd0);
        chk("rst_strobe", 64'(bit_strobe), 64'd0);
        chk("rst_crc",    64'(crc_out), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_strobe", 64'(bit_strobe), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].idx, vecs[i].arg, vecs[i].poke);
            check_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted at bit 20 of a CMD8 frame aborts immediately.
        @(negedge clk);
        cmd_index = 6'd8; cmd_arg = 32'h0000_01AA; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            @(negedge clk);
            if (bit_strobe) n++;
        end
        chk("abort_reach", 64'(n), 64'd20);
        reset = 1'b1;
        #1;
        chk("abort_oe",   64'(cmd_oe), 64'd0);
        chk("abort_cmd",  64'(cmd_out), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_strb", 64'(bit_strobe), 64'd0);
        chk("abort_crc",  64'(crc_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy || bit_strobe) n++;
        end
        chk("abort_quiet", 64'(n), 64'd0);
        run_frame(vecs[0].idx, vecs[0].arg, 1'b0);
        check_frame(vecs[0], "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
